// File: rtl/butterfly_r2_pipe_if.sv
// Sample-pair input channel and result output channel of the radix-2 butterfly.
interface butterfly_r2_pipe_if #(
    parameter int DW    = 16,
    parameter int LOG2N = 6,
    parameter int TAGW  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   in_a;
    logic [2*DW-1:0]   in_b;
    logic [LOG2N-2:0]  in_k;
    logic              in_scale;
    logic              in_inv;
    logic [TAGW-1:0]   in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   out_a;
    logic [2*DW-1:0]   out_b;
    logic [TAGW-1:0]   out_tag;
    logic              out_sat;

    modport slave (
        input  in_valid, in_a, in_b, in_k, in_scale, in_inv, in_tag, out_ready,
        output in_ready, out_valid, out_a, out_b, out_tag, out_sat
    );

    modport master (
        output in_valid, in_a, in_b, in_k, in_scale, in_inv, in_tag, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_tag, out_sat
    );
endinterface

// File: rtl/butterfly_r2_pipe.sv
// Four-stage radix-2 DIF butterfly: A' = (A+B)s, B' = ((A-B)s)W^k, with rounding,
// saturation, forward/inverse twiddles, tag pass-through and whole-pipe stall.
module butterfly_r2_pipe #(
    parameter int DW    = 16,
    parameter int TW    = 16,
    parameter int LOG2N = 6,
    parameter int TAGW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    butterfly_r2_pipe_if.slave bus
);
    localparam int  NH  = 2 ** (LOG2N - 1);
    localparam int  KW  = LOG2N - 1;
    localparam int  PW  = DW + TW;
    localparam int  DW2 = DW + 2;
    localparam real PI  = 3.14159265358979323846;
    localparam logic signed [PW:0] RND = {{(PW + 2 - TW){1'b0}}, 1'b1, {(TW - 2){1'b0}}};

    typedef logic signed [DW-1:0] data_t;
    typedef logic signed [TW-1:0] tw_t;
    typedef logic signed [PW-1:0] prod_t;

    function automatic tw_t rom_entry(input int k, input bit is_sin);
        real    ang;
        real    v;
        longint q;
        longint maxv;
        ang  = 2.0 * PI * real'(k) / real'(2 ** LOG2N);
        v    = is_sin ? -$sin(ang) : $cos(ang);
        q    = longint'(v * real'(longint'(1) << (TW - 1)));
        maxv = (longint'(1) << (TW - 1)) - longint'(1);
        if (q > maxv) begin
            q = maxv;
        end else begin
            q = q;
        end
        return tw_t'(q);
    endfunction

    // {overflow, value}: halve with floor, or saturate the DW+1-bit sum to DW
    function automatic logic [DW:0] fit_sum(input logic signed [DW:0] x, input logic halve);
        logic [DW:0] r;
        if (halve) begin
            r = {1'b0, x[DW:1]};
        end else if (x[DW] != x[DW-1]) begin
            r = {1'b1, x[DW], {(DW - 1){~x[DW]}}};
        end else begin
            r = {1'b0, x[DW-1:0]};
        end
        return r;
    endfunction

    function automatic logic [DW:0] round_sat(input logic signed [PW:0] x);
        logic [DW+1:0] t;
        logic [DW:0]   r;
        t = DW2'((x + RND) >>> (TW - 1));
        if (t[DW+1:DW-1] == 3'b000 || t[DW+1:DW-1] == 3'b111) begin
            r = {1'b0, t[DW-1:0]};
        end else begin
            r = {1'b1, t[DW+1], {(DW - 1){~t[DW+1]}}};
        end
        return r;
    endfunction

    function automatic tw_t neg_sat(input tw_t w);
        tw_t r;
        if (w == {1'b1, {(TW - 1){1'b0}}}) begin
            r = {1'b0, {(TW - 1){1'b1}}};
        end else begin
            r = -w;
        end
        return r;
    endfunction

    tw_t rom_wr_s [NH];
    tw_t rom_wi_s [NH];

    for (genvar g = 0; g < NH; g++) begin : g_rom
        localparam tw_t WR = rom_entry(g, 1'b0);
        localparam tw_t WI = rom_entry(g, 1'b1);
        assign rom_wr_s[g] = WR;
        assign rom_wi_s[g] = WI;
    end

    logic            stall_s;
    logic            adv_s;
    logic            out_valid_r;
    logic [2*DW-1:0] out_a_r;
    logic [2*DW-1:0] out_b_r;
    logic [TAGW-1:0] out_tag_r;
    logic            out_sat_r;

    assign stall_s       = out_valid_r & ~bus.out_ready;
    assign adv_s         = ~stall_s;
    assign bus.in_ready  = ~stall_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_a     = out_a_r;
    assign bus.out_b     = out_b_r;
    assign bus.out_tag   = out_tag_r;
    assign bus.out_sat   = out_sat_r;

    data_t              a_re_s, a_im_s, b_re_s, b_im_s;
    logic signed [DW:0] sum_re_s, sum_im_s, dif_re_s, dif_im_s;
    logic [DW:0]        fs_re_s, fs_im_s, fd_re_s, fd_im_s;

    assign a_re_s   = data_t'(bus.in_a[2*DW-1:DW]);
    assign a_im_s   = data_t'(bus.in_a[DW-1:0]);
    assign b_re_s   = data_t'(bus.in_b[2*DW-1:DW]);
    assign b_im_s   = data_t'(bus.in_b[DW-1:0]);
    assign sum_re_s = {a_re_s[DW-1], a_re_s} + {b_re_s[DW-1], b_re_s};
    assign sum_im_s = {a_im_s[DW-1], a_im_s} + {b_im_s[DW-1], b_im_s};
    assign dif_re_s = {a_re_s[DW-1], a_re_s} - {b_re_s[DW-1], b_re_s};
    assign dif_im_s = {a_im_s[DW-1], a_im_s} - {b_im_s[DW-1], b_im_s};
    assign fs_re_s  = fit_sum(sum_re_s, bus.in_scale);
    assign fs_im_s  = fit_sum(sum_im_s, bus.in_scale);
    assign fd_re_s  = fit_sum(dif_re_s, bus.in_scale);
    assign fd_im_s  = fit_sum(dif_im_s, bus.in_scale);

    logic            v1_r, s1_inv_r, s1_sat_r;
    data_t           s1_sr_r, s1_si_r, s1_dr_r, s1_di_r;
    logic [KW-1:0]   s1_k_r;
    logic [TAGW-1:0] s1_tag_r;

    logic            v2_r, s2_k0_r, s2_sat_r;
    data_t           s2_ar_r, s2_ai_r, s2_dr_r, s2_di_r;
    tw_t             s2_wr_r, s2_wi_r;
    logic [TAGW-1:0] s2_tag_r;

    logic            v3_r, s3_k0_r, s3_sat_r;
    data_t           s3_ar_r, s3_ai_r, s3_dr_r, s3_di_r;
    prod_t           s3_prr_r, s3_pii_r, s3_pri_r, s3_pir_r;
    logic [TAGW-1:0] s3_tag_r;

    tw_t w_re_s, w_im_s;

    // Twiddle lookup, conjugated for the inverse transform
    always_comb begin
        w_re_s = rom_wr_s[s1_k_r];
        if (s1_inv_r) begin
            w_im_s = neg_sat(rom_wi_s[s1_k_r]);
        end else begin
            w_im_s = rom_wi_s[s1_k_r];
        end
    end

    logic signed [PW:0] re_full_s, im_full_s;
    logic [DW:0]        re_fit_s, im_fit_s;
    logic [2*DW-1:0]    b_next_s;
    logic               sat4_s;

    // Complex combine with rounding; k==0 passes d through untouched
    always_comb begin
        re_full_s = {s3_prr_r[PW-1], s3_prr_r} - {s3_pii_r[PW-1], s3_pii_r};
        im_full_s = {s3_pri_r[PW-1], s3_pri_r} + {s3_pir_r[PW-1], s3_pir_r};
        re_fit_s  = round_sat(re_full_s);
        im_fit_s  = round_sat(im_full_s);
        if (s3_k0_r) begin
            b_next_s = {s3_dr_r, s3_di_r};
            sat4_s   = 1'b0;
        end else begin
            b_next_s = {re_fit_s[DW-1:0], im_fit_s[DW-1:0]};
            sat4_s   = re_fit_s[DW] | im_fit_s[DW];
        end
    end

    // Pipeline advance: all stages move together unless the output is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r        <= 1'b0;
            s1_sr_r     <= '0;
            s1_si_r     <= '0;
            s1_dr_r     <= '0;
            s1_di_r     <= '0;
            s1_k_r      <= '0;
            s1_inv_r    <= 1'b0;
            s1_tag_r    <= '0;
            s1_sat_r    <= 1'b0;
            v2_r        <= 1'b0;
            s2_ar_r     <= '0;
            s2_ai_r     <= '0;
            s2_dr_r     <= '0;
            s2_di_r     <= '0;
            s2_wr_r     <= '0;
            s2_wi_r     <= '0;
            s2_k0_r     <= 1'b0;
            s2_tag_r    <= '0;
            s2_sat_r    <= 1'b0;
            v3_r        <= 1'b0;
            s3_ar_r     <= '0;
            s3_ai_r     <= '0;
            s3_dr_r     <= '0;
            s3_di_r     <= '0;
            s3_prr_r    <= '0;
            s3_pii_r    <= '0;
            s3_pri_r    <= '0;
            s3_pir_r    <= '0;
            s3_k0_r     <= 1'b0;
            s3_tag_r    <= '0;
            s3_sat_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_a_r     <= '0;
            out_b_r     <= '0;
            out_tag_r   <= '0;
            out_sat_r   <= 1'b0;
        end else if (adv_s) begin
            v1_r     <= bus.in_valid;
            s1_sr_r  <= fs_re_s[DW-1:0];
            s1_si_r  <= fs_im_s[DW-1:0];
            s1_dr_r  <= fd_re_s[DW-1:0];
            s1_di_r  <= fd_im_s[DW-1:0];
            s1_k_r   <= bus.in_k;
            s1_inv_r <= bus.in_inv;
            s1_tag_r <= bus.in_tag;
            s1_sat_r <= fs_re_s[DW] | fs_im_s[DW] | fd_re_s[DW] | fd_im_s[DW];

            v2_r     <= v1_r;
            s2_ar_r  <= s1_sr_r;
            s2_ai_r  <= s1_si_r;
            s2_dr_r  <= s1_dr_r;
            s2_di_r  <= s1_di_r;
            s2_wr_r  <= w_re_s;
            s2_wi_r  <= w_im_s;
            s2_k0_r  <= (s1_k_r == {KW{1'b0}});
            s2_tag_r <= s1_tag_r;
            s2_sat_r <= s1_sat_r;

            v3_r     <= v2_r;
            s3_ar_r  <= s2_ar_r;
            s3_ai_r  <= s2_ai_r;
            s3_dr_r  <= s2_dr_r;
            s3_di_r  <= s2_di_r;
            s3_prr_r <= prod_t'(s2_dr_r) * prod_t'(s2_wr_r);
            s3_pii_r <= prod_t'(s2_di_r) * prod_t'(s2_wi_r);
            s3_pri_r <= prod_t'(s2_dr_r) * prod_t'(s2_wi_r);
            s3_pir_r <= prod_t'(s2_di_r) * prod_t'(s2_wr_r);
            s3_k0_r  <= s2_k0_r;
            s3_tag_r <= s2_tag_r;
            s3_sat_r <= s2_sat_r;

            out_valid_r <= v3_r;
            if (v3_r) begin
                out_a_r   <= {s3_ar_r, s3_ai_r};
                out_b_r   <= b_next_s;
                out_tag_r <= s3_tag_r;
                out_sat_r <= s3_sat_r | sat4_s;
            end else begin
                out_a_r   <= '0;
                out_b_r   <= '0;
                out_tag_r <= '0;
                out_sat_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end
endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Randomised scoreboard bench for butterfly_r2_pipe against an integer reference model.
module tb_butterfly_r2_pipe;
    localparam int DW = 16, TW = 16, LOG2N = 6, TAGW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    butterfly_r2_pipe_if #(.DW(DW), .LOG2N(LOG2N), .TAGW(TAGW)) bus ();
    butterfly_r2_pipe #(.DW(DW), .TW(TW), .LOG2N(LOG2N), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct { int ar; int ai; int br; int bi; int k; bit sc; bit inv; int tag; } stim_t;
    typedef struct { logic [31:0] a; logic [31:0] b; int tag; bit sat; int edge_i; int stalls; } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    edge_i = 0;
    int    stall_total = 0;
    int    in_ready_low = 0;
    int    hold_used = 0;
    int    ready_mode = 0;
    bit    want_valid = 1'b0;
    bit    prev_stall = 1'b0;
    logic [31:0] prev_a, prev_b;
    logic [7:0]  prev_tag;
    logic        prev_sat;
    logic [31:0] cap_a [256];
    logic [31:0] cap_b [256];
    bit          cap_sat [256];
    int          cap_cnt [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    function automatic int clampv(input longint v, inout bit sat);
        if (v > 32767) begin sat = 1'b1; return 32767; end
        if (v < -32768) begin sat = 1'b1; return -32768; end
        return int'(v);
    endfunction

    function automatic int twid(input int k, input bit im_part);
        real    ang;
        real    v;
        longint q;
        ang = 2.0 * 3.14159265358979323846 * k / 64.0;
        v   = im_part ? -$sin(ang) : $cos(ang);
        q   = longint'(v * 32768.0);
        if (q > 32767) q = 32767;
        return int'(q);
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t   e;
        bit     sat = 1'b0;
        int     sr, si, dr, di, wr, wi, br, bi;
        longint re, im;
        if (s.sc) begin
            sr = (s.ar + s.br) >>> 1;  si = (s.ai + s.bi) >>> 1;
            dr = (s.ar - s.br) >>> 1;  di = (s.ai - s.bi) >>> 1;
        end else begin
            sr = clampv(s.ar + s.br, sat);  si = clampv(s.ai + s.bi, sat);
            dr = clampv(s.ar - s.br, sat);  di = clampv(s.ai - s.bi, sat);
        end
        if (s.k == 0) begin
            br = dr;  bi = di;
        end else begin
            wr = twid(s.k, 1'b0);
            wi = twid(s.k, 1'b1);
            if (s.inv) wi = (wi == -32768) ? 32767 : -wi;
            re = longint'(dr) * wr - longint'(di) * wi;
            im = longint'(dr) * wi + longint'(di) * wr;
            br = clampv((re + 16384) >>> 15, sat);
            bi = clampv((im + 16384) >>> 15, sat);
        end
        e.a = pk(sr, si);  e.b = pk(br, bi);  e.sat = sat;  e.tag = s.tag;
        e.edge_i = 0;  e.stalls = 0;
        return e;
    endfunction

    function automatic stim_t mk(input int ar, ai, br, bi, k, input bit sc, inv, input int tag);
        stim_t s;
        s.ar = ar; s.ai = ai; s.br = br; s.bi = bi; s.k = k; s.sc = sc; s.inv = inv; s.tag = tag;
        return s;
    endfunction

    function automatic int rval();
        int r = int'($urandom_range(0, 7));
        if (r == 0) return 32767;
        if (r == 1) return -32768;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // One clock: check visible outputs, drive the next edge, score the transfers it will make
    task automatic cycle(input bit rst);
        stim_t s;
        exp_t  e;
        @(negedge clk);
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_stable_a", bus.out_a, prev_a);
                chk("stall_stable_b", bus.out_b, prev_b);
                chk("stall_stable_tag", bus.out_tag, prev_tag);
                chk("stall_stable_sat", bus.out_sat, prev_sat);
            end
            if (bus.out_valid !== 1'b1)
                chk("idle_outputs_zero", {bus.out_a, bus.out_b, bus.out_tag, bus.out_sat}, 64'd0);
        end
        case (ready_mode)
            1: bus.out_ready = ($urandom_range(0, 99) < 70);
            2: begin
                if (bus.out_valid && bus.out_tag == 8'd1 && hold_used < 3) begin
                    bus.out_ready = 1'b0;
                    hold_used++;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
            default: bus.out_ready = 1'b1;
        endcase
        reset = rst;
        if (want_valid && stim_q.size() > 0) begin
            s = stim_q[0];
            bus.in_valid = 1'b1;
            bus.in_a = pk(s.ar, s.ai);
            bus.in_b = pk(s.br, s.bi);
            bus.in_k = s.k[4:0];
            bus.in_scale = s.sc;
            bus.in_inv = s.inv;
            bus.in_tag = s.tag[7:0];
        end else begin
            bus.in_valid = 1'b0;
        end
        #1;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output_tag", bus.out_tag, 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_tag", bus.out_tag, e.tag[7:0]);
                    chk("out_a", bus.out_a, e.a);
                    chk("out_b", bus.out_b, e.b);
                    chk("out_sat", bus.out_sat, e.sat);
                    chk("latency", edge_i - e.edge_i, 4 + stall_total - e.stalls);
                    cap_a[bus.out_tag] = bus.out_a;
                    cap_b[bus.out_tag] = bus.out_b;
                    cap_sat[bus.out_tag] = bus.out_sat;
                    cap_cnt[bus.out_tag]++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model(stim_q.pop_front());
                e.edge_i = edge_i;
                e.stalls = stall_total;
                exp_q.push_back(e);
            end
            if (bus.out_valid && !bus.out_ready) stall_total++;
            if (!bus.in_ready) in_ready_low++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_a = bus.out_a;  prev_b = bus.out_b;
            prev_tag = bus.out_tag;  prev_sat = bus.out_sat;
        end
        edge_i++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            cycle(1'b0);
            n++;
        end
        checks++;
        if (stim_q.size() > 0 || exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout pending_in=%0d pending_out=%0d required=0", stim_q.size(), exp_q.size());
        end
    endtask

    initial begin
        exp_t m;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_k = '0;
        bus.in_scale = 1'b0; bus.in_inv = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) cap_cnt[i] = 0;

        // pin the reference model to hand-derived values
        m = model(mk(1000, -2000, 200, 400, 0, 1'b1, 1'b0, 0));
        chk("model_k0_a", m.a, pk(600, -800));
        chk("model_k0_b", m.b, pk(400, -1200));
        m = model(mk(1000, 0, 0, 0, 16, 1'b0, 1'b0, 0));
        chk("model_k16_fwd_b", m.b, pk(0, -1000));
        m = model(mk(1000, 0, 0, 0, 16, 1'b0, 1'b1, 0));
        chk("model_k16_inv_b", m.b, pk(0, 1000));
        m = model(mk(32767, 0, 1, 0, 0, 1'b0, 1'b0, 0));
        chk("model_sat_b", m.b, pk(32766, 0));
        chk("model_sat_flag", m.sat, 1'b1);

        // reset held two cycles while a sample is offered
        want_valid = 1'b1;
        stim_q.push_back(mk(5, 5, 5, 5, 3, 1'b0, 1'b0, 200));
        cycle(1'b1);
        cycle(1'b1);
        stim_q.delete();
        want_valid = 1'b0;
        cycle(1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_a", bus.out_a, 32'd0);
        chk("rst_out_b", bus.out_b, 32'd0);
        chk("rst_out_tag", bus.out_tag, 8'd0);
        chk("rst_out_sat", bus.out_sat, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0);
            chk("rst_no_output", bus.out_valid, 1'b0);
        end

        // directed vectors, back-to-back with mixed modes
        want_valid = 1'b1;
        stim_q.push_back(mk(1000, -2000, 200, 400, 0, 1'b1, 1'b0, 100));
        stim_q.push_back(mk(1000, 0, 0, 0, 16, 1'b0, 1'b0, 101));
        stim_q.push_back(mk(1000, 0, 0, 0, 16, 1'b0, 1'b1, 102));
        stim_q.push_back(mk(32767, 0, 1, 0, 0, 1'b0, 1'b0, 103));
        stim_q.push_back(mk(100, 0, 1, 0, 0, 1'b0, 1'b0, 104));
        drain(50);
        chk("k0_out_a", cap_a[100], pk(600, -800));
        chk("k0_out_b", cap_b[100], pk(400, -1200));
        chk("k0_out_sat", cap_sat[100], 1'b0);
        chk("k16_fwd_out_a", cap_a[101], pk(1000, 0));
        chk("k16_fwd_out_b", cap_b[101], pk(0, -1000));
        chk("k16_inv_out_a", cap_a[102], pk(1000, 0));
        chk("k16_inv_out_b", cap_b[102], pk(0, 1000));
        chk("sat_out_a", cap_a[103], pk(32767, 0));
        chk("sat_out_b", cap_b[103], pk(32766, 0));
        chk("sat_out_sat", cap_sat[103], 1'b1);
        chk("after_sat_out_sat", cap_sat[104], 1'b0);

        // backpressure: hold tag 1 for three cycles
        for (int t = 0; t < 8; t++)
            stim_q.push_back(mk(rval(), rval(), rval(), rval(), int'($urandom_range(0, 31)),
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t));
        ready_mode = 2;
        hold_used = 0;
        in_ready_low = 0;
        drain(60);
        chk("bp_in_ready_low_cycles", in_ready_low, 3);
        for (int t = 0; t < 8; t++) chk("bp_tag_once", cap_cnt[t], 1);
        ready_mode = 0;

        // reset with three samples in flight
        for (int t = 50; t < 54; t++) cap_cnt[t] = 0;
        for (int t = 50; t < 53; t++) stim_q.push_back(mk(rval(), rval(), rval(), rval(), 7, 1'b0, 1'b0, t));
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        stim_q.delete();
        want_valid = 1'b0;
        cycle(1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0);
            chk("midrst_no_output", bus.out_valid, 1'b0);
        end
        want_valid = 1'b1;
        stim_q.push_back(mk(300, -300, 100, 50, 5, 1'b1, 1'b1, 53));
        drain(30);
        for (int t = 50; t < 53; t++) chk("midrst_discarded", cap_cnt[t], 0);
        chk("midrst_new_sample", cap_cnt[53], 1);

        // randomised traffic with random gaps and backpressure
        ready_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            if (stim_q.size() < 2)
                stim_q.push_back(mk(rval(), rval(), rval(), rval(), int'($urandom_range(0, 31)),
                                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                    int'($urandom_range(0, 255))));
            want_valid = ($urandom_range(0, 3) != 0);
            cycle(1'b0);
        end
        want_valid = 1'b1;
        ready_mode = 0;
        drain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
